multicycle_control: RTL

Main control FSM for the multi-cycle MIPS datapath. It sits on the opposite side of the PC-update interface: it generates `PCwrite`, `PCwrite_cond` and `pc_src`, which the PC register consumes. It also drives every other datapath enable and mux select, one instruction step per clock. It decodes the opcode held in the instruction register and counts retired instructions for board-level debug.

---
 rtl/mc_ctrl_pkg.sv | 48 ++++
 rtl/retire_counter.sv | 24 ++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes
// and the mux/ALU select codes consumed by the PC, ALU control and datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] AluBReg   = 2'b00;
  localparam logic [1:0] AluBFour  = 2'b01;
  localparam logic [1:0] AluBImm   = 2'b10;
  localparam logic [1:0] AluBImmSh = 2'b11;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter, wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count one per cycle with inc high; cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Moore machine: every
// datapath enable and select is decoded from the state register alone.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  output logic             PCwrite,
  output logic             PCwrite_cond,
  output logic [1:0]       pc_src,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  state_e state_q, state_d;
  logic   illegal_op_q;
  logic   decode_illegal;

  // An unsupported opcode retires straight out of DECODE.
  assign decode_illegal = (state_q == StDecode) && !op_is_legal(opcode);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; opcode only matters when leaving DECODE and MEM_ADR.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpLw) ? StMemRead : ((opcode == OpSw) ? StMemWrite : StFetch);
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecute:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StAddiEx:   state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Output decode; anything not named for a state stays 0 (incl. encodings 12-15).
  always_comb begin
    PCwrite      = 1'b0;
    PCwrite_cond = 1'b0;
    pc_src       = PcSrcAlu;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = AluBReg;
    ALUOp        = AluOpAdd;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = AluBFour;
        PCwrite = 1'b1;
        pc_src  = PcSrcAlu;
      end
      StDecode: begin
        // Branch target precomputed while the opcode is decoded.
        ALUSrcB = AluBImmSh;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = AluBImm;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        ALUSrcB = AluBReg;
        ALUOp   = AluOpFunct;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = AluBReg;
        ALUOp        = AluOpSub;
        PCwrite_cond = 1'b1;
        pc_src       = PcSrcAluOut;
      end
      StJump: begin
        PCwrite = 1'b1;
        pc_src  = PcSrcJump;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = AluBImm;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Last state of each instruction, plus DECODE for an illegal opcode.
  always_comb begin
    instr_done = decode_illegal;
    case (state_q)
      StMemWb, StMemWrite, StAluWb, StBranch, StJump, StAddiWb: instr_done = 1'b1;
      default: ;
    endcase
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op_q <= 1'b0;
    end else if (decode_illegal) begin
      illegal_op_q <= 1'b1;
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (instr_done),
    .count (instr_count)
  );

  assign state      = state_q;
  assign illegal_op = illegal_op_q;

endmodule
